// File: rtl/eject_sink.sv
// eject_sink
//   Ejection endpoint on one router output port. Flits arriving on the
//   router staging link are buffered per virtual channel. They are drained
//   to a host in round-robin order across VCs. Each drained flit returns
//   one credit to the router after CR_DELAY cycles. The block also counts
//   completed packets and flags framing and overflow errors.
//
// Handshake on the host side:
//   out_flit is valid whenever out_valid is 1. A flit transfers on every
//   rising edge where out_valid and out_ready are both 1. While out_valid
//   is 1 and out_ready is 0, out_flit and the grant hold steady. The one
//   exception is a newly arrived flit on a VC that comes earlier in
//   round-robin order; it may take the grant.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   in_flit      flit from router staging; bit FLIT_W-1 is the valid bit
//   out_cr_flit  credit to router; carries the valid bit and VC field, all other bits 0
//   out_flit     head flit of the granted VC buffer (combinational)
//   out_valid    out_flit holds a flit
//   out_ready    host accepts out_flit this cycle
//   pkt_count    number of tail/headtail flits drained; wraps
//   err_proto    sticky; a framing violation was seen
//   err_ovf      sticky; a flit arrived at a full VC buffer and was dropped
//   buf_empty    all VC buffers are empty
module eject_sink #(
    parameter int FLIT_W    = 32,
    parameter int NUM_VC    = 4,
    parameter int VC_BIT    = 2,
    parameter int BUF_DEPTH = 4,
    parameter int CR_DELAY  = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [FLIT_W-1:0] in_flit,
    output logic [FLIT_W-1:0] out_cr_flit,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              err_proto,
    output logic              err_ovf,
    output logic              buf_empty
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;

    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    // Per-VC framing state; frame_q is the state register.
    typedef enum logic {IDLE = 1'b0, INPKT = 1'b1} frame_state_t;

    logic [FLIT_W-1:0] mem    [NUM_VC][BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr [NUM_VC];
    logic [OCC_W-1:0]  occ    [NUM_VC];
    frame_state_t      frame_q [NUM_VC];
    frame_state_t      frame_d [NUM_VC];

    logic [VC_BIT-1:0] rr_ptr;
    logic [VC_BIT-1:0] grant;
    logic [VC_BIT-1:0] scan_idx;
    logic              found;

    logic              in_valid;
    logic [1:0]        in_type;
    logic [VC_BIT-1:0] in_vc;
    logic              in_full;
    logic              push;
    logic              drop;
    logic              pop;
    logic              proto_hit;
    logic [NUM_VC-1:0] push_vec;
    logic [NUM_VC-1:0] pop_vec;

    // Stages 0..CR_DELAY-1 form the delay pipe. Stage CR_DELAY is the
    // output register. A pop at edge N therefore shows up after edge
    // N+CR_DELAY.
    logic [VC_BIT:0]   cr_pipe [CR_DELAY+1];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_valid = in_flit[FLIT_W-1];
    assign in_type  = in_flit[FLIT_W-2:FLIT_W-3];
    assign in_vc    = in_flit[FLIT_W-4 -: VC_BIT];

    // Round-robin grant: the first non-empty VC at or after rr_ptr.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            scan_idx = VC_BIT'((int'(rr_ptr) + i) % NUM_VC);
            if (!found && occ[scan_idx] != '0) begin
                grant = scan_idx;
                found = 1'b1;
            end
        end
    end

    assign out_valid = found;
    assign buf_empty = ~found;
    assign out_flit  = found ? mem[grant][rd_ptr[grant]] : '0;
    assign pop       = found & out_ready;

    // A full VC still accepts a flit when it is popped in the same cycle.
    assign in_full = (occ[in_vc] == OCC_W'(BUF_DEPTH));
    assign push    = in_valid && (!in_full || (pop && grant == in_vc));
    assign drop    = in_valid && !push;

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_vec[v] = push && (in_vc == VC_BIT'(v));
            pop_vec[v]  = pop && (grant == VC_BIT'(v));
        end
    end

    // Framing next state. The FSM advances only on accepted writes.
    // Head always enters INPKT. Tail and headtail always return to IDLE.
    // Body keeps the current state.
    always_comb begin
        proto_hit = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            frame_d[v] = frame_q[v];
            if (push_vec[v]) begin
                case (in_type)
                    TYPE_BODY: begin
                        if (frame_q[v] == IDLE) proto_hit = 1'b1;
                    end
                    TYPE_HEAD: begin
                        if (frame_q[v] == INPKT) proto_hit = 1'b1;
                        frame_d[v] = INPKT;
                    end
                    TYPE_TAIL: begin
                        if (frame_q[v] == IDLE) proto_hit = 1'b1;
                        frame_d[v] = IDLE;
                    end
                    default: begin
                        if (frame_q[v] == INPKT) proto_hit = 1'b1;
                        frame_d[v] = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) frame_q[v] <= IDLE;
        end else begin
            for (int v = 0; v < NUM_VC; v++) frame_q[v] <= frame_d[v];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
                occ[v]    <= '0;
            end
            rr_ptr    <= '0;
            pkt_count <= '0;
            err_proto <= 1'b0;
            err_ovf   <= 1'b0;
            for (int i = 0; i <= CR_DELAY; i++) cr_pipe[i] <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_vec[v]) wr_ptr[v] <= ptr_inc(wr_ptr[v]);
                if (pop_vec[v])  rd_ptr[v] <= ptr_inc(rd_ptr[v]);
                if (push_vec[v] && !pop_vec[v])      occ[v] <= occ[v] + 1'b1;
                else if (pop_vec[v] && !push_vec[v]) occ[v] <= occ[v] - 1'b1;
            end
            if (pop) begin
                rr_ptr <= VC_BIT'((int'(grant) + 1) % NUM_VC);
                // Type MSB is set for tail (10) and headtail (11).
                if (out_flit[FLIT_W-2]) pkt_count <= pkt_count + 1'b1;
            end
            if (proto_hit) err_proto <= 1'b1;
            if (drop)      err_ovf   <= 1'b1;
            // The VC is masked so that idle stages read as all-zero.
            cr_pipe[0] <= {pop, grant & {VC_BIT{pop}}};
            for (int i = 1; i <= CR_DELAY; i++) cr_pipe[i] <= cr_pipe[i-1];
        end
    end

    // Buffer storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[in_vc][wr_ptr[in_vc]] <= in_flit;
    end

    always_comb begin
        out_cr_flit                     = '0;
        out_cr_flit[FLIT_W-1]           = cr_pipe[CR_DELAY][VC_BIT];
        out_cr_flit[FLIT_W-4 -: VC_BIT] = cr_pipe[CR_DELAY][VC_BIT-1:0];
    end

endmodule

// File: tb/tb_eject_sink.sv
// tb_eject_sink
//   Directed bench for eject_sink: reset, single headtail, multi-flit packet,
//   overflow, round-robin order, framing errors and back-to-back streaming.
module tb_eject_sink;

    localparam int FLIT_W    = 32;
    localparam int NUM_VC    = 4;
    localparam int VC_BIT    = 2;
    localparam int BUF_DEPTH = 4;
    localparam int CR_DELAY  = 2;
    localparam int CNT_W     = 16;

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [FLIT_W-1:0] in_flit = '0;
    logic [FLIT_W-1:0] out_cr_flit;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  pkt_count;
    logic              err_proto;
    logic              err_ovf;
    logic              buf_empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    eject_sink #(
        .FLIT_W(FLIT_W), .NUM_VC(NUM_VC), .VC_BIT(VC_BIT),
        .BUF_DEPTH(BUF_DEPTH), .CR_DELAY(CR_DELAY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .out_cr_flit(out_cr_flit),
        .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
        .pkt_count(pkt_count), .err_proto(err_proto), .err_ovf(err_ovf),
        .buf_empty(buf_empty)
    );

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int vc, input int pay);
        logic [FLIT_W-1:0] f;
        f        = '0;
        f[31]    = 1'b1;
        f[30:29] = t;
        f[28:27] = vc[1:0];
        f[26:0]  = pay[26:0];
        return f;
    endfunction

    function automatic logic [FLIT_W-1:0] cr(input int vc);
        logic [FLIT_W-1:0] f;
        f        = '0;
        f[31]    = 1'b1;
        f[28:27] = vc[1:0];
        return f;
    endfunction

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_flit   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, buf_empty, err_proto, err_ovf} !== 4'b0100) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=0100", {out_valid, buf_empty, err_proto, err_ovf});
        end
        checks++;
        if (out_flit !== '0 || out_cr_flit !== '0 || pkt_count !== '0) begin
            failures++;
            $display("FAIL rst_data got flit=%h cr=%h pkt=%0d exp=0", out_flit, out_cr_flit, pkt_count);
        end
        // Buffer two flits, pop one so that a credit is in flight, then reset mid-cycle.
        in_flit = mk(T_HT, 0, 1); step();
        in_flit = mk(T_HT, 0, 2); step();
        in_flit = '0;
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        checks++;
        if (pkt_count !== 16'd1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got pkt=%0d valid=%b exp pkt=1 valid=1", pkt_count, out_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || buf_empty !== 1'b1 || out_flit !== '0 ||
            out_cr_flit !== '0 || pkt_count !== '0) begin
            failures++;
            $display("FAIL rst_async got valid=%b empty=%b flit=%h cr=%h pkt=%0d exp 0/1/0/0/0",
                     out_valid, buf_empty, out_flit, out_cr_flit, pkt_count);
        end
        #2 rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (out_cr_flit !== '0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_flush cyc=%0d got cr=%h valid=%b exp 0", c, out_cr_flit, out_valid);
            end
        end
    endtask

    task automatic test_headtail();
        do_reset();
        out_ready = 1'b1;
        in_flit = mk(T_HT, 2, 'h5A); step();
        in_flit = '0;
        checks++;
        if (out_valid !== 1'b1 || out_flit !== mk(T_HT, 2, 'h5A)) begin
            failures++;
            $display("FAIL ht_flit got valid=%b flit=%h exp 1 %h", out_valid, out_flit, mk(T_HT, 2, 'h5A));
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== 16'd1 || out_cr_flit !== '0) begin
            failures++;
            $display("FAIL ht_pop got valid=%b pkt=%0d cr=%h exp 0 1 0", out_valid, pkt_count, out_cr_flit);
        end
        step();
        checks++;
        if (out_cr_flit !== '0) begin
            failures++;
            $display("FAIL ht_cr_early got=%h exp=0", out_cr_flit);
        end
        step();
        checks++;
        if (out_cr_flit !== cr(2)) begin
            failures++;
            $display("FAIL ht_cr got=%h exp=%h", out_cr_flit, cr(2));
        end
        step();
        checks++;
        if (out_cr_flit !== '0) begin
            failures++;
            $display("FAIL ht_cr_hold got=%h exp=0", out_cr_flit);
        end
    endtask

    task automatic test_packet();
        logic [FLIT_W-1:0] pk [3];
        logic [FLIT_W-1:0] exp_cr [6];
        pk[0] = mk(T_HEAD, 1, 'h111);
        pk[1] = mk(T_BODY, 1, 'h222);
        pk[2] = mk(T_TAIL, 1, 'h333);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_flit = pk[i];
            step();
        end
        in_flit = '0;
        step(); step();
        checks++;
        if (out_valid !== 1'b1 || out_flit !== pk[0] || out_cr_flit !== '0) begin
            failures++;
            $display("FAIL pkt_hold got valid=%b flit=%h cr=%h exp 1 %h 0", out_valid, out_flit, out_cr_flit, pk[0]);
        end
        out_ready = 1'b1;
        // Pops at the next three edges; credits follow two edges later.
        exp_cr[0] = '0; exp_cr[1] = '0; exp_cr[2] = cr(1);
        exp_cr[3] = cr(1); exp_cr[4] = cr(1); exp_cr[5] = '0;
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                checks++;
                if (out_flit !== pk[c]) begin
                    failures++;
                    $display("FAIL pkt_order idx=%0d got=%h exp=%h", c, out_flit, pk[c]);
                end
            end
            step();
            checks++;
            if (out_cr_flit !== exp_cr[c]) begin
                failures++;
                $display("FAIL pkt_cr cyc=%0d got=%h exp=%h", c, out_cr_flit, exp_cr[c]);
            end
        end
        checks++;
        if (pkt_count !== 16'd1 || err_proto !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL pkt_end got pkt=%0d proto=%b valid=%b exp 1 0 0", pkt_count, err_proto, out_valid);
        end
    endtask

    task automatic test_overflow();
        int ncr;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_flit = mk(T_HT, 0, 'h11 + i);
            step();
        end
        checks++;
        if (err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_full got=%b exp=0", err_ovf);
        end
        in_flit = mk(T_HT, 0, 'h15); step();
        in_flit = '0;
        checks++;
        if (err_ovf !== 1'b1 || out_flit !== mk(T_HT, 0, 'h11)) begin
            failures++;
            $display("FAIL ovf_drop got ovf=%b flit=%h exp 1 %h", err_ovf, out_flit, mk(T_HT, 0, 'h11));
        end
        out_ready = 1'b1;
        ncr = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_cr_flit[31]) ncr++;
        end
        checks++;
        if (ncr != 4 || pkt_count !== 16'd4 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_credits got cr=%0d pkt=%0d valid=%b exp 4 4 0", ncr, pkt_count, out_valid);
        end
        // Same scenario, but the 5th flit meets a simultaneous pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_flit = mk(T_HT, 0, 'h11 + i);
            step();
        end
        in_flit = mk(T_HT, 0, 'h15);
        out_ready = 1'b1;
        step();
        in_flit = '0;
        checks++;
        if (err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pushpop got=%b exp=0", err_ovf);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_flit !== mk(T_HT, 0, 'h12 + k)) begin
                failures++;
                $display("FAIL ovf_order idx=%0d got=%h exp=%h", k, out_flit, mk(T_HT, 0, 'h12 + k));
            end
            step();
        end
        checks++;
        if (pkt_count !== 16'd5 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_end got pkt=%0d valid=%b exp 5 0", pkt_count, out_valid);
        end
    endtask

    task automatic test_round_robin();
        int v;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            in_flit = mk(T_HT, i, 'h100 + i);
            step();
        end
        in_flit = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_flit !== mk(T_HT, k, 'h100 + k)) begin
                failures++;
                $display("FAIL rr0 idx=%0d got=%h exp=%h", k, out_flit, mk(T_HT, k, 'h100 + k));
            end
            step();
        end
        // One flit on VC0 moves the pointer to 1.
        out_ready = 1'b0;
        in_flit = mk(T_HT, 0, 'h200); step();
        in_flit = '0;
        out_ready = 1'b1; step();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_flit = mk(T_HT, i, 'h300 + i);
            step();
        end
        in_flit = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            v = (k + 1) % 4;
            checks++;
            if (out_flit !== mk(T_HT, v, 'h300 + v)) begin
                failures++;
                $display("FAIL rr1 idx=%0d got=%h exp=%h", k, out_flit, mk(T_HT, v, 'h300 + v));
            end
            step();
        end
    endtask

    task automatic test_proto();
        logic st;
        do_reset();
        out_ready = 1'b1;
        in_flit = mk(T_BODY, 3, 'h77); step();
        in_flit = '0;
        checks++;
        if (err_proto !== 1'b1 || out_flit !== mk(T_BODY, 3, 'h77)) begin
            failures++;
            $display("FAIL proto_body got err=%b flit=%h exp 1 %h", err_proto, out_flit, mk(T_BODY, 3, 'h77));
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || pkt_count !== '0) begin
            failures++;
            $display("FAIL proto_drain got valid=%b pkt=%0d exp 0 0", out_valid, pkt_count);
        end
        step(); step();
        checks++;
        if (out_cr_flit !== cr(3)) begin
            failures++;
            $display("FAIL proto_cr got=%h exp=%h", out_cr_flit, cr(3));
        end
        do_reset();
        in_flit = mk(T_HEAD, 0, 1); step();
        st = dut.frame_q[0];
        checks++;
        if (err_proto !== 1'b0 || st !== 1'b1) begin
            failures++;
            $display("FAIL proto_head1 got err=%b st=%b exp 0 1", err_proto, st);
        end
        in_flit = mk(T_HEAD, 0, 2); step();
        in_flit = '0;
        st = dut.frame_q[0];
        checks++;
        if (err_proto !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("FAIL proto_head2 got err=%b st=%b exp 1 1", err_proto, st);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_flit !== mk(T_HEAD, 0, k + 1)) begin
                failures++;
                $display("FAIL proto_buf idx=%0d got=%h exp=%h", k, out_flit, mk(T_HEAD, 0, k + 1));
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_flit = mk(T_HT, 1, 'h400 + k);
            step();
            checks++;
            if (out_flit !== mk(T_HT, 1, 'h400 + k)) begin
                failures++;
                $display("FAIL b2b idx=%0d got=%h exp=%h", k, out_flit, mk(T_HT, 1, 'h400 + k));
            end
        end
        in_flit = '0;
        step();
        checks++;
        if (pkt_count !== 16'd6 || out_valid !== 1'b0 || err_ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end got pkt=%0d valid=%b ovf=%b exp 6 0 0", pkt_count, out_valid, err_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_headtail();
        test_packet();
        test_overflow();
        test_round_robin();
        test_proto();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
